// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline control: state encoding,
// register index width and the bundle of per-stage enable/flush controls.
package core_pkg;

   localparam int          REG_IDX_W = 5;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_MD    = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   typedef enum logic [1:0] {
      S_RUN   = ST_RUN,
      S_MD    = ST_MD,
      S_FLUSH = ST_FLUSH
   } state_t;

   // First field is the MSB, so the packed value reads pc_we..ex_mem_flush.
   typedef struct packed {
      logic pc_we;
      logic pc_sel_redirect;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_we;
      logic id_ex_flush;
      logic ex_mem_we;
      logic ex_mem_flush;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_NONE     = pipe_ctl_t'(8'b0000_0000);
   localparam pipe_ctl_t CTL_RUN      = pipe_ctl_t'(8'b1010_1010);
   localparam pipe_ctl_t CTL_LOAD_USE = pipe_ctl_t'(8'b0000_1110);
   localparam pipe_ctl_t CTL_REDIRECT = pipe_ctl_t'(8'b1111_1110);
   localparam pipe_ctl_t CTL_FLUSH    = pipe_ctl_t'(8'b1011_1010);
   localparam pipe_ctl_t CTL_MD_STALL = pipe_ctl_t'(8'b0000_0011);

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load still sitting in EX.
module hazard_detect
   import core_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_mem_read,
   output logic                 load_use
);

   logic [REG_IDX_W-1:0] src_idx [2];
   logic [1:0]           src_use;
   logic [1:0]           src_hit;

   assign src_idx[0] = id_rs1;
   assign src_idx[1] = id_rs2;
   assign src_use    = {id_use_rs2, id_use_rs1};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_use[gi] && (src_idx[gi] == ex_rd);
      end
   endgenerate

   // x0 is hardwired to zero, so a load into it never creates a dependency.
   assign load_use = ex_mem_read && (ex_rd != '0) && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: priority mux of freeze/redirect/mul-div/load-use controls,
// post-redirect flush window, mul/div watchdog and stall-cycle counter.
module pipe_hazard_ctrl
   import core_pkg::*;
#(
   parameter int FLUSH_CYCLES  = 2,
   parameter int MD_MAX_CYCLES = 64,
   parameter int CNT_W         = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [REG_IDX_W-1:0] i_id_rs1,
   input  logic [REG_IDX_W-1:0] i_id_rs2,
   input  logic                 i_id_use_rs1,
   input  logic                 i_id_use_rs2,
   input  logic [REG_IDX_W-1:0] i_ex_rd,
   input  logic                 i_ex_mem_read,
   input  logic                 i_ex_redirect,
   input  logic                 i_ex_md_start,
   input  logic                 i_md_done,
   input  logic                 i_dmem_stall,
   output logic                 o_pc_we,
   output logic                 o_pc_sel_redirect,
   output logic                 o_if_id_we,
   output logic                 o_if_id_flush,
   output logic                 o_id_ex_we,
   output logic                 o_id_ex_flush,
   output logic                 o_ex_mem_we,
   output logic                 o_ex_mem_flush,
   output logic                 o_md_timeout,
   output logic [CNT_W-1:0]     o_stall_cycles
);

   localparam int                FCNT_W      = 3;
   localparam int                MD_W        = $clog2(MD_MAX_CYCLES + 1);
   localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
   localparam logic [MD_W-1:0]   MD_LIMIT    = MD_W'(MD_MAX_CYCLES);
   localparam logic [MD_W-1:0]   MD_LAST     = MD_W'(MD_MAX_CYCLES - 1);

   state_t             state_reg, state_next;
   logic [FCNT_W-1:0]  fcnt_reg, fcnt_next;
   logic [MD_W-1:0]    mdcnt_reg, mdcnt_next;
   logic               timeout_reg, timeout_next;
   logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
   pipe_ctl_t          ctl;
   logic               md_tick;
   logic               load_use;

   hazard_detect u_hazard_detect (
      .id_rs1      (i_id_rs1),
      .id_rs2      (i_id_rs2),
      .id_use_rs1  (i_id_use_rs1),
      .id_use_rs2  (i_id_use_rs2),
      .ex_rd       (i_ex_rd),
      .ex_mem_read (i_ex_mem_read),
      .load_use    (load_use)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg     <= S_RUN;
         fcnt_reg      <= '0;
         mdcnt_reg     <= '0;
         timeout_reg   <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         fcnt_reg      <= fcnt_next;
         mdcnt_reg     <= mdcnt_next;
         timeout_reg   <= timeout_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      fcnt_next    = fcnt_reg;
      mdcnt_next   = mdcnt_reg;
      timeout_next = timeout_reg;
      md_tick      = 1'b0;
      ctl          = CTL_NONE;

      if (i_reset || i_dmem_stall) begin
         ctl = CTL_NONE;
      end else if (state_reg == S_MD) begin
         // EX is frozen behind the mul/div, so a redirect seen here is stale.
         if (i_md_done) begin
            ctl        = CTL_RUN;
            state_next = S_RUN;
            mdcnt_next = '0;
         end else begin
            ctl     = CTL_MD_STALL;
            md_tick = 1'b1;
         end
      end else if (i_ex_redirect) begin
         ctl = CTL_REDIRECT;
         if (FLUSH_CYCLES > 1) begin
            state_next = S_FLUSH;
            fcnt_next  = FCNT_RELOAD;
         end else begin
            state_next = S_RUN;
         end
      end else if (state_reg == S_FLUSH) begin
         ctl       = CTL_FLUSH;
         fcnt_next = fcnt_reg - FCNT_W'(1);
         if (fcnt_reg == FCNT_W'(1)) begin
            state_next = S_RUN;
         end
      end else if (i_ex_md_start && !i_md_done) begin
         ctl        = CTL_MD_STALL;
         state_next = S_MD;
         md_tick    = 1'b1;
      end else if (load_use) begin
         ctl = CTL_LOAD_USE;
      end else begin
         ctl = CTL_RUN;
      end

      // Watchdog saturates at the limit; the timeout flag stays set until reset.
      if (md_tick) begin
         if (mdcnt_reg != MD_LIMIT) begin
            mdcnt_next = mdcnt_reg + MD_W'(1);
         end
         if (mdcnt_reg >= MD_LAST) begin
            timeout_next = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (!ctl.pc_we && (stall_cnt_reg != '1)) begin
         stall_cnt_next = stall_cnt_reg + CNT_W'(1);
      end
   end

   assign o_pc_we           = ctl.pc_we;
   assign o_pc_sel_redirect = ctl.pc_sel_redirect;
   assign o_if_id_we        = ctl.if_id_we;
   assign o_if_id_flush     = ctl.if_id_flush;
   assign o_id_ex_we        = ctl.id_ex_we;
   assign o_id_ex_flush     = ctl.id_ex_flush;
   assign o_ex_mem_we       = ctl.ex_mem_we;
   assign o_ex_mem_flush    = ctl.ex_mem_flush;
   assign o_md_timeout      = timeout_reg;
   assign o_stall_cycles    = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table on one instance, plus
// random stimulus on two differently parameterised instances against a model.
module tb_pipe_hazard_ctrl;

   // Control byte order: pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush
   localparam logic [7:0] C_NONE = 8'h00;
   localparam logic [7:0] C_RUN  = 8'hAA;
   localparam logic [7:0] C_LU   = 8'h0E;
   localparam logic [7:0] C_RD   = 8'hFE;
   localparam logic [7:0] C_FL   = 8'hBA;
   localparam logic [7:0] C_MD   = 8'h03;

   typedef struct {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [4:0] rd;
      logic       memrd;
      logic       redir;
      logic       mds;
      logic       mdd;
      logic       dst;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [7:0] ctl;
      logic       to;
      int         cnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, use1, use2, memrd, redir, mds, mdd, dst;
   logic [4:0] rs1, rs2, rd;

   logic       pc_we_a, sel_a, ifwe_a, iff_a, idwe_a, idf_a, exwe_a, exf_a, to_a;
   logic [31:0] cnt_a;
   logic       pc_we_b, sel_b, ifwe_b, iff_b, idwe_b, idf_b, exwe_b, exf_b, to_b;
   logic [3:0] cnt_b;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MD_MAX_CYCLES(8), .CNT_W(32)) u_dut_a (
      .i_clk(clk), .i_reset(reset), .i_id_rs1(rs1), .i_id_rs2(rs2),
      .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_rd(rd), .i_ex_mem_read(memrd),
      .i_ex_redirect(redir), .i_ex_md_start(mds), .i_md_done(mdd), .i_dmem_stall(dst),
      .o_pc_we(pc_we_a), .o_pc_sel_redirect(sel_a), .o_if_id_we(ifwe_a), .o_if_id_flush(iff_a),
      .o_id_ex_we(idwe_a), .o_id_ex_flush(idf_a), .o_ex_mem_we(exwe_a), .o_ex_mem_flush(exf_a),
      .o_md_timeout(to_a), .o_stall_cycles(cnt_a)
   );

   pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .MD_MAX_CYCLES(4), .CNT_W(4)) u_dut_b (
      .i_clk(clk), .i_reset(reset), .i_id_rs1(rs1), .i_id_rs2(rs2),
      .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_rd(rd), .i_ex_mem_read(memrd),
      .i_ex_redirect(redir), .i_ex_md_start(mds), .i_md_done(mdd), .i_dmem_stall(dst),
      .o_pc_we(pc_we_b), .o_pc_sel_redirect(sel_b), .o_if_id_we(ifwe_b), .o_if_id_flush(iff_b),
      .o_id_ex_we(idwe_b), .o_id_ex_flush(idf_b), .o_ex_mem_we(exwe_b), .o_ex_mem_flush(exf_b),
      .o_md_timeout(to_b), .o_stall_cycles(cnt_b)
   );

   logic [7:0]  ctl_o [2];
   logic        to_o  [2];
   logic [31:0] cnt_o [2];
   assign ctl_o[0] = {pc_we_a, sel_a, ifwe_a, iff_a, idwe_a, idf_a, exwe_a, exf_a};
   assign ctl_o[1] = {pc_we_b, sel_b, ifwe_b, iff_b, idwe_b, idf_b, exwe_b, exf_b};
   assign to_o[0]  = to_a;
   assign to_o[1]  = to_b;
   assign cnt_o[0] = cnt_a;
   assign cnt_o[1] = {28'd0, cnt_b};

   int     checks = 0;
   int     errors = 0;
   vec_t   tbl[$];

   // Reference model, one slot per instance, written from the behavioural rules.
   int     p_fc   [2] = '{2, 3};
   int     p_md   [2] = '{8, 4};
   longint p_cmax [2] = '{64'hFFFF_FFFF, 64'd15};
   bit     m_md_busy    [2];
   int     m_flush_left [2];
   int     m_md_waited  [2];
   bit     m_to         [2];
   longint m_cnt        [2];

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
      end
   endtask

   task automatic model_step(input int k, input stim_t s, output logic [7:0] c);
      bit lu;
      lu = s.memrd && (s.rd != 5'd0) &&
           ((s.use1 && (s.rd == s.rs1)) || (s.use2 && (s.rd == s.rs2)));
      c = C_NONE;
      if (s.rst) begin
         m_md_busy[k] = 1'b0; m_flush_left[k] = 0; m_md_waited[k] = 0;
         m_to[k] = 1'b0; m_cnt[k] = 0;
         return;
      end
      if (s.dst) begin
         c = C_NONE;
      end else if (m_md_busy[k]) begin
         if (s.mdd) begin
            c = C_RUN; m_md_busy[k] = 1'b0; m_md_waited[k] = 0;
         end else begin
            c = C_MD; m_md_waited[k]++;
            if (m_md_waited[k] >= p_md[k]) m_to[k] = 1'b1;
         end
      end else if (s.redir) begin
         c = C_RD; m_flush_left[k] = p_fc[k] - 1;
      end else if (m_flush_left[k] > 0) begin
         c = C_FL; m_flush_left[k]--;
      end else if (s.mds && !s.mdd) begin
         c = C_MD; m_md_busy[k] = 1'b1; m_md_waited[k] = 1;
         if (1 >= p_md[k]) m_to[k] = 1'b1;
      end else if (lu) begin
         c = C_LU;
      end else begin
         c = C_RUN;
      end
      if (!c[7] && (m_cnt[k] < p_cmax[k])) m_cnt[k]++;
   endtask

   task automatic apply(input stim_t s);
      logic [7:0] mc;
      @(posedge clk);
      #1;
      reset = s.rst; rs1 = s.rs1; rs2 = s.rs2; use1 = s.use1; use2 = s.use2;
      rd = s.rd; memrd = s.memrd; redir = s.redir; mds = s.mds; mdd = s.mdd; dst = s.dst;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("model_timeout", k, 64'(to_o[k]), 64'(m_to[k]));
         chk("model_stall_cnt", k, 64'(cnt_o[k]), 64'(m_cnt[k]));
         model_step(k, s, mc);
         chk("model_ctl", k, 64'(ctl_o[k]), 64'(mc));
      end
   endtask

   function automatic stim_t st(bit r, bit lu, bit rdr, bit ms, bit md, bit ds);
      stim_t s;
      s.rst = r; s.rs1 = lu ? 5'd5 : 5'd1; s.rs2 = 5'd2; s.use1 = lu; s.use2 = 1'b0;
      s.rd = 5'd5; s.memrd = lu; s.redir = rdr; s.mds = ms; s.mdd = md; s.dst = ds;
      return s;
   endfunction

   task automatic add(input stim_t s, input logic [7:0] c, input logic to, input int n);
      vec_t v;
      v.s = s; v.ctl = c; v.to = to; v.cnt = n;
      tbl.push_back(v);
   endtask

   initial begin
      stim_t s;
      reset = 1'b1; rs1 = '0; rs2 = '0; use1 = 0; use2 = 0; rd = '0;
      memrd = 0; redir = 0; mds = 0; mdd = 0; dst = 0;
      for (int k = 0; k < 2; k++) begin
         m_md_busy[k] = 0; m_flush_left[k] = 0; m_md_waited[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
      end

      // Reset, then load-use hits and misses
      add(st(1,0,0,0,0,0), C_NONE, 0, 0);
      add(st(0,0,0,0,0,0), C_RUN,  0, 0);
      add(st(0,1,0,0,0,0), C_LU,   0, 0);
      add(st(0,0,0,0,0,0), C_RUN,  0, 1);
      s = st(0,1,0,0,0,0); s.rd = 5'd0; s.rs1 = 5'd0; add(s, C_RUN, 0, 1);
      s = st(0,0,0,0,0,0); s.memrd = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.use2 = 1; add(s, C_LU, 0, 1);
      s.use2 = 0; add(s, C_RUN, 0, 2);
      // Redirect, then redirect re-armed inside the flush window
      add(st(0,0,1,0,0,0), C_RD,  0, 2);
      add(st(0,0,0,0,0,0), C_FL,  0, 2);
      add(st(0,0,0,0,0,0), C_RUN, 0, 2);
      add(st(0,0,1,0,0,0), C_RD,  0, 2);
      add(st(0,0,1,0,0,0), C_RD,  0, 2);
      add(st(0,0,0,0,0,0), C_FL,  0, 2);
      add(st(0,0,0,0,0,0), C_RUN, 0, 2);
      // Mul/div finishing on the fifth cycle, then start+done together
      add(st(0,0,0,1,0,0), C_MD, 0, 2);
      for (int j = 0; j < 4; j++) add(st(0,0,0,0,0,0), C_MD, 0, 3 + j);
      add(st(0,0,0,0,1,0), C_RUN, 0, 7);
      add(st(0,0,0,0,0,0), C_RUN, 0, 7);
      add(st(0,0,0,1,1,0), C_RUN, 0, 7);
      // Data-memory freeze on the last flush cycle
      add(st(0,0,1,0,0,0), C_RD,   0, 7);
      add(st(0,0,0,0,0,1), C_NONE, 0, 7);
      add(st(0,0,0,0,0,1), C_NONE, 0, 8);
      add(st(0,0,0,0,0,1), C_NONE, 0, 9);
      add(st(0,0,0,0,0,0), C_FL,   0, 10);
      add(st(0,0,0,0,0,0), C_RUN,  0, 10);
      // Freeze beats redirect beats load-use
      add(st(0,1,1,0,0,1), C_NONE, 0, 10);
      add(st(0,1,1,0,0,0), C_RD,   0, 11);
      add(st(0,0,0,0,0,0), C_FL,   0, 11);
      add(st(0,0,0,0,0,0), C_RUN,  0, 11);
      // Redirect ignored while mul/div busy; freeze inside mul/div
      add(st(0,0,0,1,0,0), C_MD,   0, 11);
      add(st(0,0,1,0,0,0), C_MD,   0, 12);
      add(st(0,0,0,0,0,1), C_NONE, 0, 13);
      add(st(0,0,0,0,1,0), C_RUN,  0, 14);
      // Watchdog: eight waiting cycles set the sticky flag; reset mid-mul/div clears it
      add(st(0,0,0,1,0,0), C_MD, 0, 14);
      for (int j = 1; j < 8; j++) add(st(0,0,0,0,0,0), C_MD, 0, 14 + j);
      add(st(0,0,0,0,0,0), C_MD,   1, 22);
      add(st(0,0,0,0,1,0), C_RUN,  1, 23);
      add(st(0,0,0,0,0,0), C_RUN,  1, 23);
      add(st(0,0,0,1,0,0), C_MD,   1, 23);
      add(st(1,0,0,0,0,0), C_NONE, 1, 24);
      add(st(0,0,0,0,0,0), C_RUN,  0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].s);
         chk("tbl_ctl", i, 64'(ctl_o[0]), 64'(tbl[i].ctl));
         chk("tbl_timeout", i, 64'(to_o[0]), 64'(tbl[i].to));
         chk("tbl_stall_cnt", i, 64'(cnt_o[0]), 64'(tbl[i].cnt));
         $display("vec %0d: ctl=%02h timeout=%0b stall_cycles=%0d", i, ctl_o[0], to_o[0], cnt_o[0]);
      end

      for (int i = 0; i < 4000; i++) begin
         s.rst   = ($urandom_range(0, 99) == 0);
         s.rs1   = 5'($urandom_range(0, 3));
         s.rs2   = 5'($urandom_range(0, 3));
         s.use1  = 1'($urandom_range(0, 1));
         s.use2  = 1'($urandom_range(0, 1));
         s.rd    = 5'($urandom_range(0, 3));
         s.memrd = 1'($urandom_range(0, 1));
         s.redir = ($urandom_range(0, 7) == 0);
         s.mds   = ($urandom_range(0, 7) == 0);
         s.mdd   = ($urandom_range(0, 3) == 0);
         s.dst   = ($urandom_range(0, 5) == 0);
         apply(s);
         if (i % 500 == 0)
            $display("rand %0d: ctl_a=%02h ctl_b=%02h cnt_a=%0d cnt_b=%0d", i, ctl_o[0], ctl_o[1], cnt_o[0], cnt_o[1]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
